mmio_sig_monitor: RTL and testbench



---
 rtl/mmio_mon_pkg.sv | 38 +++
 rtl/mmio_mon_fifo.sv | 58 +++++
 rtl/mmio_sig_monitor.sv | 195 +++++++++++++++++++
 tb/tb_mmio_sig_monitor.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_mon_pkg.sv
// Shared constants and types for the MMIO signal monitor: window offsets,
// FSM state and done-reason encodings, and the dump record layout.
package mmio_mon_pkg;

  localparam int unsigned STOP_OFF    = 32'h00;
  localparam int unsigned TRAP_OFF    = 32'h08;
  localparam int unsigned DUMP_OFF    = 32'h10;
  localparam int unsigned DUMP_STRIDE = 32'h08;

  // Record fields sized for the widest supported channel count (8 -> 4-bit id)
  localparam int REC_CH_W   = 4;
  localparam int REC_IDX_W  = 8;
  localparam int REC_DATA_W = 64;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    REASON_NONE  = 2'd0,
    REASON_STOP  = 2'd1,
    REASON_TRAP  = 2'd2,
    REASON_CYCLE = 2'd3
  } done_reason_e;

  typedef struct packed {
    logic [REC_CH_W-1:0]   ch;
    logic [REC_IDX_W-1:0]  idx;
    logic [REC_DATA_W-1:0] data;
  } dump_rec_t;

  function automatic int unsigned dump_offset(input int unsigned ch);
    return DUMP_OFF + DUMP_STRIDE * ch;
  endfunction

endpackage

// File: rtl/mmio_mon_fifo.sv
// Synchronous FIFO for dump records. Output is driven from stored state only
// and reads as zero when empty; a push into a full FIFO succeeds if a pop
// happens in the same cycle.
module mmio_mon_fifo #(
  parameter int Width = 8,
  parameter int Depth = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [Width-1:0] push_data,
  input  logic             pop,
  output logic [Width-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int PtrW = $clog2(Depth);

  logic [Width-1:0] mem [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]    count_q;
  logic             do_push, do_pop;

  assign full    = (count_q == (PtrW+1)'(Depth));
  assign empty   = (count_q == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rd_data = empty ? '0 : mem[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_q] <= push_data;
    end
  end

  // Depth is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + PtrW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (PtrW+1)'(1);
        2'b01:   count_q <= count_q - (PtrW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/mmio_sig_monitor.sv
// Decodes stop/trap/dump writes from the tiny-SoC MMIO port, queues dump
// records and sequences RUN -> DRAIN -> DONE. Define MMIO_MON_CYCLE_LIMIT_EN
// to build the cycle-limit timeout (done reason 3).
module mmio_sig_monitor
  import mmio_mon_pkg::*;
#(
  parameter int                   AddrWidth   = 31,
  parameter int                   DataWidth   = 64,
  parameter logic [AddrWidth-1:0] SigBase     = 31'h60000000,
  parameter int                   NumDumpCh   = 2,
  parameter int                   IdxWidth    = 6,
  parameter int                   FifoDepth   = 8,
  parameter int                   DrainCycles = 500,
  parameter int                   CycleWidth  = 32
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            mmio_req_i,
  input  logic                            mmio_we_i,
  input  logic [AddrWidth-1:0]            mmio_addr_i,
  input  logic [DataWidth-1:0]            mmio_wdata_i,
  input  logic [DataWidth/8-1:0]          mmio_strb_i,
  input  logic                            trap_stop_en_i,
  input  logic [CycleWidth-1:0]           sim_len_i,
  output logic                            rec_valid_o,
  input  logic                            rec_ready_i,
  output logic [$clog2(NumDumpCh):0]      rec_ch_o,
  output logic [IdxWidth-1:0]             rec_idx_o,
  output logic [DataWidth-1:0]            rec_data_o,
  output logic                            trap_seen_o,
  output logic                            overflow_o,
  output logic                            draining_o,
  output logic                            done_o,
  output logic [1:0]                      done_reason_o
);

  localparam int ChWidth  = $clog2(NumDumpCh) + 1;
  localparam int RecWidth = ChWidth + IdxWidth + DataWidth;
  localparam int DrainW   = (DrainCycles > 2) ? $clog2(DrainCycles) : 1;

  localparam logic [AddrWidth-1:0] STOP_ADDR = SigBase + AddrWidth'(STOP_OFF);
  localparam logic [AddrWidth-1:0] TRAP_ADDR = SigBase + AddrWidth'(TRAP_OFF);

  state_e              state_q, state_d;
  done_reason_e        reason_q, reason_d;
  logic [DrainW-1:0]   drain_cnt_q, drain_cnt_d;
  logic [IdxWidth-1:0] idx_cnt_q [NumDumpCh];

  logic                 wr_en, stop_hit, trap_hit, limit_hit;
  logic [NumDumpCh-1:0] dump_hit;
  logic                 dump_any;
  logic [ChWidth-1:0]   dump_ch;
  logic [IdxWidth-1:0]  dump_idx;
  logic                 trap_seen_q, overflow_q;
  logic                 fifo_pop, fifo_full, fifo_empty;
  logic [RecWidth-1:0]  fifo_rd_data;
  logic                 unused_strb;

  // Byte strobes play no part in decode.
  assign unused_strb = ^mmio_strb_i;

  assign wr_en    = mmio_req_i && mmio_we_i && (state_q == ST_RUN);
  assign stop_hit = wr_en && (mmio_addr_i == STOP_ADDR);
  assign trap_hit = wr_en && (mmio_addr_i == TRAP_ADDR);

  always_comb begin
    dump_hit = '0;
    dump_any = 1'b0;
    dump_ch  = '0;
    dump_idx = '0;
    for (int k = 0; k < NumDumpCh; k++) begin
      if (wr_en && (mmio_addr_i == SigBase + AddrWidth'(dump_offset(unsigned'(k))))) begin
        dump_hit[k] = 1'b1;
        dump_any    = 1'b1;
        dump_ch     = ChWidth'(k);
        dump_idx    = idx_cnt_q[k];
      end
    end
  end

  // x0 is never dumped, so channel 0 numbering starts at 1.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int k = 0; k < NumDumpCh; k++) begin
        idx_cnt_q[k] <= (k == 0) ? IdxWidth'(1) : '0;
      end
    end else begin
      for (int k = 0; k < NumDumpCh; k++) begin
        if (dump_hit[k]) begin
          idx_cnt_q[k] <= idx_cnt_q[k] + IdxWidth'(1);
        end
      end
    end
  end

`ifdef MMIO_MON_CYCLE_LIMIT_EN
  logic [CycleWidth-1:0] cycle_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cycle_q <= '0;
    end else begin
      cycle_q <= cycle_q + CycleWidth'(1);
    end
  end

  assign limit_hit = (sim_len_i != '0) && (cycle_q == sim_len_i - CycleWidth'(1))
                     && (state_q != ST_DONE);
`else
  logic unused_sim_len;
  assign unused_sim_len = ^sim_len_i;
  assign limit_hit      = 1'b0;
`endif

  // The cycle limit outranks stop/trap; DrainCycles of 0 or 1 skips DRAIN.
  always_comb begin
    state_d     = state_q;
    reason_d    = reason_q;
    drain_cnt_d = drain_cnt_q;
    unique case (state_q)
      ST_RUN: begin
        if (limit_hit) begin
          state_d  = ST_DONE;
          reason_d = REASON_CYCLE;
        end else if (stop_hit || (trap_hit && trap_stop_en_i)) begin
          reason_d = stop_hit ? REASON_STOP : REASON_TRAP;
          if (DrainCycles <= 1) begin
            state_d = ST_DONE;
          end else begin
            state_d     = ST_DRAIN;
            drain_cnt_d = DrainW'(DrainCycles - 1);
          end
        end
      end
      ST_DRAIN: begin
        if (limit_hit) begin
          state_d  = ST_DONE;
          reason_d = REASON_CYCLE;
        end else if ((drain_cnt_q == DrainW'(1)) || (drain_cnt_q == '0)) begin
          state_d = ST_DONE;
        end else begin
          drain_cnt_d = drain_cnt_q - DrainW'(1);
        end
      end
      default: begin
        state_d = state_q;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_RUN;
      reason_q    <= REASON_NONE;
      drain_cnt_q <= '0;
      trap_seen_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      reason_q    <= reason_d;
      drain_cnt_q <= drain_cnt_d;
      if (trap_hit) begin
        trap_seen_q <= 1'b1;
      end
      if (dump_any && fifo_full && !fifo_pop) begin
        overflow_q <= 1'b1;
      end
    end
  end

  assign fifo_pop = rec_valid_o && rec_ready_i;

  mmio_mon_fifo #(
    .Width (RecWidth),
    .Depth (FifoDepth)
  ) u_fifo (
    .clk       (clk_i),
    .rst       (rst_i),
    .push      (dump_any),
    .push_data ({dump_ch, dump_idx, mmio_wdata_i}),
    .pop       (fifo_pop),
    .rd_data   (fifo_rd_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign rec_valid_o                         = !fifo_empty;
  assign {rec_ch_o, rec_idx_o, rec_data_o}   = fifo_rd_data;
  assign trap_seen_o                         = trap_seen_q;
  assign overflow_o                          = overflow_q;
  assign draining_o                          = (state_q == ST_DRAIN);
  assign done_o                              = (state_q == ST_DONE);
  assign done_reason_o                       = reason_q;

endmodule

// File: tb/tb_mmio_sig_monitor.sv
// Scoreboard bench for mmio_sig_monitor: directed writes push expected
// records, a negedge monitor pops and compares on every record handshake.
module tb_mmio_sig_monitor;
  import mmio_mon_pkg::*;

  localparam logic [30:0] SIG_BASE = 31'h60000000;
  localparam logic [30:0] A_STOP   = 31'(STOP_OFF);
  localparam logic [30:0] A_TRAP   = 31'(TRAP_OFF);
  localparam logic [30:0] A_D0     = 31'(dump_offset(0));
  localparam logic [30:0] A_D1     = 31'(dump_offset(1));

  logic        clk = 1'b0;
  logic        rst;
  logic        mmio_req, mmio_we;
  logic [30:0] mmio_addr;
  logic [63:0] mmio_wdata;
  logic [7:0]  mmio_strb;
  logic        trap_stop_en;
  logic [31:0] sim_len;
  logic        rec_valid, rec_ready;
  logic [1:0]  rec_ch;
  logic [5:0]  rec_idx;
  logic [63:0] rec_data;
  logic        trap_seen, overflow, draining, done;
  logic [1:0]  done_reason;

  dump_rec_t sb[$];
  int        checks = 0;
  int        passed = 0;

  always #5 clk = ~clk;

  mmio_sig_monitor #(
    .DrainCycles (5)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .mmio_req_i     (mmio_req),
    .mmio_we_i      (mmio_we),
    .mmio_addr_i    (mmio_addr),
    .mmio_wdata_i   (mmio_wdata),
    .mmio_strb_i    (mmio_strb),
    .trap_stop_en_i (trap_stop_en),
    .sim_len_i      (sim_len),
    .rec_valid_o    (rec_valid),
    .rec_ready_i    (rec_ready),
    .rec_ch_o       (rec_ch),
    .rec_idx_o      (rec_idx),
    .rec_data_o     (rec_data),
    .trap_seen_o    (trap_seen),
    .overflow_o     (overflow),
    .draining_o     (draining),
    .done_o         (done),
    .done_reason_o  (done_reason)
  );

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual === expected) passed++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  function automatic void expectRec(input int ch, input int idx, input logic [63:0] data);
    dump_rec_t r;
    r.ch   = 4'(ch);
    r.idx  = 8'(idx);
    r.data = data;
    sb.push_back(r);
  endfunction

  task automatic applyStimulus(input logic we, input logic [30:0] off, input logic [63:0] data,
                               input logic [7:0] strb);
    mmio_req   = 1'b1;
    mmio_we    = we;
    mmio_addr  = SIG_BASE + off;
    mmio_wdata = data;
    mmio_strb  = strb;
    @(posedge clk); #1;
    mmio_req   = 1'b0;
    mmio_we    = 1'b0;
    mmio_addr  = '0;
    mmio_wdata = '0;
    mmio_strb  = '0;
  endtask

  task automatic doReset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic stepCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic waitDrain();
    int n = 0;
    while ((sb.size() != 0 || rec_valid) && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("sb_drained", 64'(sb.size()), 64'd0);
  endtask

  // Monitor: a record is consumed at the next edge whenever valid && ready.
  initial begin
    dump_rec_t e;
    forever begin
      @(negedge clk);
      if (!rst && rec_valid && rec_ready) begin
        checkOutput("rec_expected", 64'(sb.size() > 0), 64'd1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          checkOutput("rec_ch",   64'(rec_ch),  64'(e.ch));
          checkOutput("rec_idx",  64'(rec_idx), 64'(e.idx));
          checkOutput("rec_data", rec_data,     e.data);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    rst = 1'b1; mmio_req = 1'b0; mmio_we = 1'b0; mmio_addr = '0; mmio_wdata = '0;
    mmio_strb = '0; trap_stop_en = 1'b0; sim_len = '0; rec_ready = 1'b0;
    doReset();

    checkOutput("reset_valid",    64'(rec_valid),   64'd0);
    checkOutput("reset_data",     rec_data,         64'd0);
    checkOutput("reset_trap",     64'(trap_seen),   64'd0);
    checkOutput("reset_overflow", 64'(overflow),    64'd0);
    checkOutput("reset_draining", 64'(draining),    64'd0);
    checkOutput("reset_done",     64'(done),        64'd0);
    checkOutput("reset_reason",   64'(done_reason), 64'd0);

    // ch0 dumps; a read and a zero-strobe write probe the write qualifier.
    rec_ready = 1'b1;
    expectRec(0, 1, 64'h11); applyStimulus(1'b1, A_D0, 64'h11, 8'hFF);
    expectRec(0, 2, 64'h22); applyStimulus(1'b1, A_D0, 64'h22, 8'hFF);
    applyStimulus(1'b0, A_D0, 64'h99, 8'hFF);
    expectRec(0, 3, 64'h33); applyStimulus(1'b1, A_D0, 64'h33, 8'h00);
    waitDrain();

    // ch1 overflow, hold while stalled, then push-while-full-and-popping.
    rec_ready = 1'b0;
    expectRec(1, 0, 64'hDEAD); applyStimulus(1'b1, A_D1, 64'hDEAD, 8'hFF);
    for (int i = 1; i <= 9; i++) begin
      if (i < 8) expectRec(1, i, 64'h100 + 64'(i));
      applyStimulus(1'b1, A_D1, 64'h100 + 64'(i), 8'hFF);
    end
    checkOutput("ovf_set",    64'(overflow),  64'd1);
    checkOutput("hold_valid", 64'(rec_valid), 64'd1);
    checkOutput("hold_idx",   64'(rec_idx),   64'd0);
    stepCycles(2);
    checkOutput("hold_data",  rec_data,       64'hDEAD);
    rec_ready = 1'b1;
    expectRec(1, 10, 64'hBEEF); applyStimulus(1'b1, A_D1, 64'hBEEF, 8'hFF);
    waitDrain();
    checkOutput("ovf_sticky", 64'(overflow), 64'd1);

    // STOP with DrainCycles=5; writes during DRAIN/DONE are ignored.
    doReset();
    checkOutput("ovf_cleared", 64'(overflow), 64'd0);
    applyStimulus(1'b1, A_STOP, 64'd0, 8'hFF);
    checkOutput("stop_draining_t1", 64'(draining), 64'd1);
    checkOutput("stop_done_t1",     64'(done),     64'd0);
    applyStimulus(1'b1, A_D0, 64'h55, 8'hFF);
    checkOutput("drain_no_rec",     64'(rec_valid), 64'd0);
    stepCycles(1);
    checkOutput("stop_done_t3",     64'(done),     64'd0);
    stepCycles(1);
    checkOutput("stop_done_t4",     64'(done),     64'd0);
    checkOutput("stop_draining_t4", 64'(draining), 64'd1);
    stepCycles(1);
    checkOutput("stop_done_t5",     64'(done),        64'd1);
    checkOutput("stop_draining_t5", 64'(draining),    64'd0);
    checkOutput("stop_reason",      64'(done_reason), 64'd1);
    applyStimulus(1'b1, A_TRAP, 64'd0, 8'hFF);
    checkOutput("done_trap_ignored", 64'(trap_seen), 64'd0);

    // TRAP without and then with trap_stop_en.
    doReset();
    trap_stop_en = 1'b0;
    applyStimulus(1'b1, A_TRAP, 64'd0, 8'hFF);
    checkOutput("trap_seen",       64'(trap_seen), 64'd1);
    checkOutput("trap_no_drain",   64'(draining),  64'd0);
    trap_stop_en = 1'b1;
    applyStimulus(1'b1, A_TRAP, 64'd0, 8'hFF);
    checkOutput("trap_draining",   64'(draining),  64'd1);
    n = 0;
    while (!done && n < 20) begin stepCycles(1); n++; end
    checkOutput("trap_done",       64'(done),        64'd1);
    checkOutput("trap_reason",     64'(done_reason), 64'd2);
    trap_stop_en = 1'b0;

    // Cycle limit of 20 with no writes, then a STOP racing it on cycle 19.
    sim_len = 32'd20;
    doReset();
    stepCycles(19);
    checkOutput("lim_done_c19", 64'(done), 64'd0);
    stepCycles(1);
`ifdef MMIO_MON_CYCLE_LIMIT_EN
    checkOutput("lim_done_c20",   64'(done),        64'd1);
    checkOutput("lim_reason_c20", 64'(done_reason), 64'd3);
`else
    checkOutput("nolim_done_c20", 64'(done),        64'd0);
`endif
    doReset();
    stepCycles(19);
    applyStimulus(1'b1, A_STOP, 64'd0, 8'hFF);
`ifdef MMIO_MON_CYCLE_LIMIT_EN
    checkOutput("race_done",   64'(done),        64'd1);
    checkOutput("race_reason", 64'(done_reason), 64'd3);
`else
    checkOutput("race_draining", 64'(draining),    64'd1);
    checkOutput("race_reason",   64'(done_reason), 64'd1);
`endif
    sim_len = '0;

    // Reset mid-DRAIN with queued records flushes and restarts numbering.
    doReset();
    rec_ready = 1'b0;
    applyStimulus(1'b1, A_D0, 64'hA1, 8'hFF);
    applyStimulus(1'b1, A_D0, 64'hA2, 8'hFF);
    applyStimulus(1'b1, A_D0, 64'hA3, 8'hFF);
    applyStimulus(1'b1, A_STOP, 64'd0, 8'hFF);
    checkOutput("pre_rst_draining", 64'(draining),  64'd1);
    checkOutput("pre_rst_valid",    64'(rec_valid), 64'd1);
    rst = 1'b1;
    stepCycles(1);
    rst = 1'b0;
    checkOutput("post_rst_valid",    64'(rec_valid), 64'd0);
    checkOutput("post_rst_draining", 64'(draining),  64'd0);
    checkOutput("post_rst_done",     64'(done),      64'd0);
    rec_ready = 1'b1;
    expectRec(0, 1, 64'h77); applyStimulus(1'b1, A_D0, 64'h77, 8'hFF);
    waitDrain();

    $display("[TB] %0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
